c4_stim_gen: RTL
================

C4_STIM_GEN -- requirements
Module: c4_stim_gen

Interface
REQ-001 The block SHALL have parameter MAXLEN, default 8, giving the maximum pattern length in bits.
REQ-002 The block SHALL have parameter GAP, default 2, giving the number of idle a=0 cycles between repetitions.
REQ-003 The block SHALL have port n_clk, input, 1 bit: the single clock; all state updates occur on its falling edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a transmission.
REQ-006 The block SHALL have port pattern, input, MAXLEN bits: bit sequence to send, bit len-1 first.
REQ-007 The block SHALL have port len, input, 4 bits: number of pattern bits to send.
REQ-008 The block SHALL have port reps, input, 4 bits: number of repetitions; 0 is treated as 1.
REQ-009 The block SHALL have port s, input, 1 bit: the detector output, monitored for hits.
REQ-010 The block SHALL have port a, output, 1 bit: serial stimulus stream to the detector.
REQ-011 The block SHALL have port ready, output, 1 bit: high only in IDLE, meaning start is accepted.
REQ-012 The block SHALL have port busy, output, 1 bit: high in SEND and GAP.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port hits, output, 8 bits: count of s rising edges seen while busy.

Function
REQ-015 The block SHALL implement FSM states IDLE, SEND, GAP and DONE, with all outputs registered.
REQ-016 In IDLE, the block SHALL hold a=0 and ready=1; start=1 at an edge SHALL latch pattern, len and reps, clear hits, and move to SEND.
REQ-017 On the accepting edge, a SHALL take pattern[len-1], so the first bit is visible in the cycle immediately after acceptance.
REQ-018 In SEND, the block SHALL present one bit per cycle in order pattern[len-1] down to pattern[0].
REQ-019 A bit index counter SHALL advance each edge and SHALL never address outside 0..len-1.
REQ-020 After the last bit: if repetitions remain, the block SHALL go to GAP; otherwise it SHALL go to DONE.
REQ-021 GAP SHALL last exactly GAP cycles with a=0, then return to SEND starting again at pattern[len-1].
REQ-022 If GAP=0, the block SHALL go straight from the last bit to the first bit of the next repetition.
REQ-023 DONE SHALL last exactly one cycle with done=1, a=0 and busy=0, then go to IDLE.
REQ-024 Total busy cycles SHALL equal reps*len + (reps-1)*GAP.
REQ-025 If len=0, the block SHALL go directly from IDLE to DONE, sending no bits.
REQ-026 If len>MAXLEN, the block SHALL clamp len to MAXLEN at latch time.
REQ-027 start SHALL be ignored while ready=0.
REQ-028 Changes to pattern, len or reps after acceptance SHALL have no effect on the transmission in progress.
REQ-029 hits SHALL increment on a cycle where s=1 and the previous sampled s=0, only while busy=1.
REQ-030 hits SHALL saturate at 255 and SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-031 If start is asserted in the DONE cycle, it SHALL be ignored; it is accepted no earlier than the following IDLE cycle.

Reset
REQ-032 When rst=1 at an n_clk falling edge, the block SHALL go to IDLE with a=0, busy=0, done=0, ready=1, hits=0, and all counters and the s history cleared.
REQ-033 rst SHALL take priority over start and over every state, including mid-SEND and mid-GAP; any transmission in progress SHALL be abandoned without a done pulse.

Verification
REQ-034 Reset: rst=1 for 2 edges with start=1 -> a=0, ready=1, busy=0, done=0, hits=0, and no transmission starts.
REQ-035 Single send: len=3, pattern=3'b101, reps=1 -> a=1,0,1 on three consecutive cycles, done=1 in the 4th cycle, ready=1 in the 5th.
REQ-036 Repeat: len=2, pattern=2'b11, reps=2, GAP=2 -> a=1,1,0,0,1,1, busy high for 6 cycles, then a single done pulse.
REQ-037 Protocol: start pulsed and pattern changed mid-SEND -> output sequence unchanged, with no second transmission.
REQ-038 Boundaries: len=0 -> done on the next cycle with a=0 throughout; len=12 with MAXLEN=8 -> exactly 8 bits sent.
REQ-039 Hits and abort: s pulsed 3 times while busy -> hits=3, then the next accepted start clears it; rst asserted mid-SEND -> IDLE and a=0 after one edge, with no done pulse.

Source files
------------

// File: rtl/c4_stim_gen.sv
// Serial stimulus generator for a sequence detector: replays a latched
// bit pattern with idle gaps and counts detector hits while busy.
module c4_stim_gen #(
  parameter int MAXLEN = 8,
  parameter int GAP    = 2
) (
  input  logic              n_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [3:0]        len,
  input  logic [3:0]        reps,
  input  logic              s,
  output logic              a,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        hits
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [3:0] MAXL =
    (MAXLEN > 15) ? 4'd15 : 4'(MAXLEN);
  localparam logic [7:0] GAPM1 =
    (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        rl_q, rl_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        gap_q, gap_d;
  logic              a_q, a_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        hits_q, hits_d;
  logic              s_q;
  logic [3:0]        len_c;

  // Shift instead of a variable part-select so the index width never
  // has to match the pattern width.
  function automatic logic bit_at(
    input logic [MAXLEN-1:0] v,
    input logic [3:0]        i
  );
    logic [MAXLEN-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rl_d    = rl_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    a_d     = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    hits_d  = hits_q;
    len_c   = (len > MAXL) ? MAXL : len;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          pat_d   = pattern;
          len_d   = len_c;
          rl_d    = (reps == 4'd0) ? 4'd0 : reps - 4'd1;
          hits_d  = 8'd0;
          ready_d = 1'b0;
          if (len_c == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SEND;
            busy_d  = 1'b1;
            idx_d   = len_c - 4'd1;
            a_d     = bit_at(pattern, len_c - 4'd1);
          end
        end
      end
      S_SEND: begin
        busy_d = 1'b1;
        if (idx_q != 4'd0) begin
          idx_d = idx_q - 4'd1;
          a_d   = bit_at(pat_q, idx_q - 4'd1);
        end else if (rl_q != 4'd0) begin
          rl_d  = rl_q - 4'd1;
          idx_d = len_q - 4'd1;
          if (GAP == 0) begin
            a_d = bit_at(pat_q, len_q - 4'd1);
          end else begin
            state_d = S_GAP;
            gap_d   = GAPM1;
          end
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == 8'd0) begin
          state_d = S_SEND;
          a_d     = bit_at(pat_q, len_q - 4'd1);
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Rising edges of s only count while the registered busy is high.
    if (busy_q && s && !s_q && hits_q != 8'hFF)
      hits_d = hits_q + 8'd1;
  end

  always_ff @(negedge n_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rl_q    <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      a_q     <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hits_q  <= '0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rl_q    <= rl_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      a_q     <= a_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hits_q  <= hits_d;
      s_q     <= s;
    end
  end

  assign a     = a_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign hits  = hits_q;

endmodule
